// File: rtl/base_tre_dec_if.sv
// Handshake and result bundle for the thermometer decoder. The slave modport is the decoder side.
// Code vectors are [0:ways-1] so bit 0 is the first position of the thermometer.
interface base_tre_dec_if #(
  parameter int unsigned ways = 2,
  parameter int unsigned cntw = 8
);
  localparam int unsigned encw = (ways > 1) ? $clog2(ways) : 1;

  logic              i_v;
  logic              i_r;
  logic [0:ways-1]   i_d;
  logic              o_v;
  logic              o_r;
  logic [0:ways-1]   o_oh;
  logic [encw-1:0]   o_enc;
  logic              o_zero;
  logic              o_err;
  logic [cntw-1:0]   o_errcnt;

  modport slave (
    input  i_v, i_d, o_r,
    output i_r, o_v, o_oh, o_enc, o_zero, o_err, o_errcnt
  );

  modport master (
    output i_v, i_d, o_r,
    input  i_r, o_v, o_oh, o_enc, o_zero, o_err, o_errcnt
  );
endinterface

// File: rtl/base_tre_dec.sv
// Two-stage thermometer decoder: leading-edge one-hot, its index, zero and bubble flags.
// Bubble detection and the error counter exist only with BASE_TRE_DEC_BUBBLE_CHK_EN defined.
module base_tre_dec #(
  parameter int unsigned ways = 2,
  parameter int unsigned cntw = 8
) (
  input logic          clk,
  input logic          reset,
  base_tre_dec_if.slave bus
);
  localparam int unsigned encw = (ways > 1) ? $clog2(ways) : 1;

  logic            s1_v_q;
  logic [0:ways-1] s1_d_q;
  logic            s1_zero_q;
  logic            o_v_q;
  logic [0:ways-1] oh_q;
  logic [encw-1:0] enc_q;
  logic            zero_q;

  logic s2_free, s1_move, in_xfer, out_xfer;

  assign s2_free  = ~o_v_q | bus.o_r;
  assign s1_move  = s1_v_q & s2_free;
  assign bus.i_r  = ~s1_v_q | s2_free;
  assign in_xfer  = bus.i_v & bus.i_r;
  assign out_xfer = o_v_q & bus.o_r;

  // Lowest rising edge; on a legal code this is the only one.
  logic [0:ways-1] oh_d;
  logic [encw-1:0] enc_d;
  always_comb begin
    logic seen;
    logic prev;
    oh_d  = '0;
    enc_d = '0;
    seen  = 1'b0;
    prev  = 1'b0;
    for (int k = 0; k < int'(ways); k++) begin
      if (!seen && s1_d_q[k] && !prev) begin
        oh_d[k] = 1'b1;
        seen    = 1'b1;
      end
      prev = s1_d_q[k];
    end
    for (int k = 0; k < int'(ways); k++) begin
      enc_d = enc_d | (oh_d[k] ? encw'(k) : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v_q    <= 1'b0;
      s1_d_q    <= '0;
      s1_zero_q <= 1'b0;
      o_v_q     <= 1'b0;
      oh_q      <= '0;
      enc_q     <= '0;
      zero_q    <= 1'b0;
    end else begin
      if (in_xfer) begin
        s1_v_q    <= 1'b1;
        s1_d_q    <= bus.i_d;
        s1_zero_q <= ~|bus.i_d;
      end else if (s1_move) begin
        s1_v_q <= 1'b0;
      end
      // Stage 2 loads whenever it is free, so a full pipe pops and pushes in one cycle.
      if (s1_move) begin
        o_v_q  <= 1'b1;
        oh_q   <= oh_d;
        enc_q  <= enc_d;
        zero_q <= s1_zero_q;
      end else if (out_xfer) begin
        o_v_q <= 1'b0;
      end
    end
  end

  assign bus.o_v    = o_v_q;
  assign bus.o_oh   = oh_q;
  assign bus.o_enc  = enc_q;
  assign bus.o_zero = zero_q;

`ifdef BASE_TRE_DEC_BUBBLE_CHK_EN
  logic            bub_d;
  logic            s1_err_q;
  logic            err_q;
  logic [cntw-1:0] errcnt_q;

  // Any 1 followed by a 0 later implies an adjacent 1->0 step somewhere.
  always_comb begin
    bub_d = 1'b0;
    for (int k = 0; k + 1 < int'(ways); k++) begin
      bub_d = bub_d | (bus.i_d[k] & ~bus.i_d[k+1]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_err_q <= 1'b0;
      err_q    <= 1'b0;
      errcnt_q <= '0;
    end else begin
      if (in_xfer) begin
        s1_err_q <= bub_d;
      end
      if (s1_move) begin
        err_q <= s1_err_q;
      end
      if (out_xfer && err_q && (errcnt_q != '1)) begin
        errcnt_q <= errcnt_q + cntw'(1);
      end
    end
  end

  assign bus.o_err    = err_q;
  assign bus.o_errcnt = errcnt_q;
`else
  assign bus.o_err    = 1'b0;
  assign bus.o_errcnt = '0;
`endif
endmodule
